// File: rtl/muldiv_seq.sv
// Iterative multiply/divide unit: shift-add multiply or restoring divide over
// WIDTH cycles, with sign handling around an unsigned magnitude core.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, PREP, RUN, FIX} state_t;
  state_t state, nstate;

  logic [CW-1:0]    cnt;
  logic [1:0]       rop;
  logic [WIDTH-1:0] md, ph, pl;
  logic             neg_q, neg_r;
  logic             accept, reject;

  // op[1]=div, op[0]=unsigned
  logic             sgn, sa, sb;
  logic [WIDTH-1:0] ma, mb;
  logic [WIDTH:0]   mul_sum, div_rs, div_diff;
  logic [2*WIDTH-1:0] prod_neg;

  always_comb begin
    sgn      = ~rop[0];
    sa       = sgn & pl[WIDTH-1];
    sb       = sgn & md[WIDTH-1];
    ma       = sa ? -pl : pl;
    mb       = sb ? -md : md;
    mul_sum  = {1'b0, ph} + {1'b0, (pl[0] ? md : '0)};
    div_rs   = {ph, pl[WIDTH-1]};
    div_diff = div_rs - {1'b0, md};
    prod_neg = -{ph, pl};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nstate;
  end

  always_comb begin
    nstate = state;
    if (flush) nstate = IDLE;
    else begin
      case (state)
        IDLE: if (start && !(op[1] && b == '0)) nstate = PREP;
        PREP: nstate = RUN;
        RUN:  if (cnt == '0) nstate = FIX;
        FIX:  nstate = IDLE;
        default: nstate = IDLE;
      endcase
    end
  end

  always_comb begin
    busy   = (state != IDLE);
    accept = (state == IDLE) & start & ~flush;
    reject = accept & op[1] & (b == '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done  <= 1'b0;
      div0  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      cnt   <= '0;
      rop   <= '0;
      md    <= '0;
      ph    <= '0;
      pl    <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else begin
      done <= 1'b0;
      div0 <= reject;
      if (!flush) begin
        case (state)
          IDLE: if (accept && !reject) begin
            rop <= op;
            pl  <= a;
            md  <= b;
          end
          PREP: begin
            // mult: md=multiplicand, pl=multiplier; div: md=divisor, pl=dividend
            md    <= rop[1] ? mb : ma;
            pl    <= rop[1] ? ma : mb;
            ph    <= '0;
            neg_q <= sa ^ sb;
            neg_r <= sa;
            cnt   <= CW'(WIDTH - 1);
          end
          RUN: begin
            cnt <= cnt - CW'(1);
            if (!rop[1]) begin
              ph <= mul_sum[WIDTH:1];
              pl <= {mul_sum[0], pl[WIDTH-1:1]};
            end else if (!div_diff[WIDTH]) begin
              ph <= div_diff[WIDTH-1:0];
              pl <= {pl[WIDTH-2:0], 1'b1};
            end else begin
              ph <= div_rs[WIDTH-1:0];
              pl <= {pl[WIDTH-2:0], 1'b0};
            end
          end
          FIX: begin
            done <= 1'b1;
            if (!rop[1]) begin
              {hi, lo} <= neg_q ? prod_neg : {ph, pl};
            end else begin
              lo <= neg_q ? -pl : pl;
              hi <= neg_r ? -ph : ph;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: WIDTH=32 and WIDTH=8 instances on one clock.
module tb_muldiv_seq;
  logic        clk = 1'b0;
  logic        reset;
  logic        start32, start8, flush;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        busy32, done32, div032, busy8, done8, div08;
  logic [31:0] hi32, lo32;
  logic [7:0]  hi8, lo8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_seq #(.WIDTH(32)) u32 (
    .clk(clk), .reset(reset), .start(start32), .op(op), .a(a), .b(b),
    .flush(flush), .busy(busy32), .done(done32), .div0(div032),
    .hi(hi32), .lo(lo32)
  );

  muldiv_seq #(.WIDTH(8)) u8 (
    .clk(clk), .reset(reset), .start(start8), .op(op), .a(a[7:0]), .b(b[7:0]),
    .flush(flush), .busy(busy8), .done(done8), .div0(div08),
    .hi(hi8), .lo(lo8)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b;
    logic [31:0] ehi, elo;
    string       nm;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic logic g_busy(input bit w8);
    return w8 ? busy8 : busy32;
  endfunction
  function automatic logic g_done(input bit w8);
    return w8 ? done8 : done32;
  endfunction
  function automatic logic [31:0] g_hi(input bit w8);
    return w8 ? {24'h0, hi8} : hi32;
  endfunction
  function automatic logic [31:0] g_lo(input bit w8);
    return w8 ? {24'h0, lo8} : lo32;
  endfunction

  // Called at a negedge; returns at the negedge where done is observed.
  task automatic run_op(input bit w8, input logic [1:0] o, input logic [31:0] aa,
                        input logic [31:0] bb, input logic [31:0] ehi,
                        input logic [31:0] elo, input string nm);
    int  lat;
    bit  got;
    op = o; a = aa; b = bb;
    if (w8) start8 = 1'b1; else start32 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0; start32 = 1'b0;
    a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3));
    @(negedge clk);
    check({nm, " busy"}, 64'(g_busy(w8)), 64'd1);
    lat = 0; got = 0;
    while (!got && lat < 100) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (g_done(w8)) got = 1;
    end
    check({nm, " latency"}, 64'(lat), w8 ? 64'd10 : 64'd34);
    check({nm, " hi"}, 64'(g_hi(w8)), 64'(ehi));
    check({nm, " lo"}, 64'(g_lo(w8)), 64'(elo));
    check({nm, " busy_at_done"}, 64'(g_busy(w8)), 64'd0);
  endtask

  initial begin
    int cnt;
    vecs[0] = '{2'b00, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, "smul -3*5"};
    vecs[1] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "umul max*max"};
    vecs[2] = '{2'b00, 32'd7,        32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFD6, "smul 7*-6"};
    vecs[3] = '{2'b01, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, "umul 2^16*2^16"};
    vecs[4] = '{2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, "sdiv -7/2"};
    vecs[5] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "sdiv min/-1"};
    vecs[6] = '{2'b10, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, "sdiv 7/-2"};
    vecs[7] = '{2'b11, 32'd7,        32'd2,        32'h00000001, 32'h00000003, "udiv 7/2"};

    reset = 1'b0; start32 = 0; start8 = 0; flush = 0; op = 0; a = 0; b = 0;
    repeat (3) @(negedge clk);
    check("reset busy", 64'(busy32 | busy8), 64'd0);
    check("reset done", 64'(done32 | done8), 64'd0);
    check("reset div0", 64'(div032 | div08), 64'd0);
    check("reset hi", {hi32, 24'h0, hi8}, 64'd0);
    check("reset lo", {lo32, 24'h0, lo8}, 64'd0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_op(0, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ehi, vecs[i].elo, vecs[i].nm);
      @(negedge clk);
      check({vecs[i].nm, " done pulse"}, 64'(done32), 64'd0);
    end

    // divide by zero: rejected, pulse only, result retained
    op = 2'b11; a = 32'd5; b = 32'd0; start32 = 1'b1;
    @(posedge clk);
    #1 start32 = 1'b0;
    @(negedge clk);
    check("div0 pulse", 64'(div032), 64'd1);
    check("div0 busy", 64'(busy32), 64'd0);
    check("div0 done", 64'(done32), 64'd0);
    @(negedge clk);
    check("div0 one cycle", 64'(div032), 64'd0);
    check("div0 no done", 64'(done32 | busy32), 64'd0);
    check("div0 hi kept", 64'(hi32), 64'd1);
    check("div0 lo kept", 64'(lo32), 64'd3);
    run_op(0, 2'b00, 32'd5, 32'd0, 32'd0, 32'd0, "smul 5*0");
    @(negedge clk);
    run_op(0, 2'b11, 32'd7, 32'd2, 32'd1, 32'd3, "udiv 7/2 again");
    @(negedge clk);

    // flush mid-RUN with start held high
    op = 2'b01; a = 32'hFFFFFFFF; b = 32'd3; start32 = 1'b1;
    @(posedge clk);
    repeat (11) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0; start32 = 1'b0;
    @(negedge clk);
    check("flush busy", 64'(busy32), 64'd0);
    cnt = 0;
    repeat (50) begin
      @(negedge clk);
      if (done32 || div032 || busy32) cnt++;
    end
    check("flush no done", 64'(cnt), 64'd0);
    check("flush hi kept", 64'(hi32), 64'd1);
    check("flush lo kept", 64'(lo32), 64'd3);

    // asynchronous reset mid-RUN
    op = 2'b01; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; start32 = 1'b1;
    @(posedge clk);
    #1 start32 = 1'b0;
    repeat (10) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("areset busy", 64'(busy32), 64'd0);
    check("areset done/div0", 64'(done32 | div032), 64'd0);
    check("areset hi", 64'(hi32), 64'd0);
    check("areset lo", 64'(lo32), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // WIDTH=8: signed min*min, then back-to-back issue in the done cycle
    run_op(1, 2'b00, 32'h80, 32'h80, 32'h40, 32'h00, "w8 smul -128*-128");
    run_op(1, 2'b01, 32'h0F, 32'h11, 32'h00, 32'hFF, "w8 umul b2b");
    @(negedge clk);
    check("w8 done pulse", 64'(done8), 64'd0);
    run_op(1, 2'b10, 32'h80, 32'hFF, 32'h00, 32'h80, "w8 sdiv min/-1");
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
